mem_arb: RTL
============

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter ADDR_W, default 14, word-address width of the synchronous single-port RAM.
REQ-002 Parameter MAX_WAIT, default 4, legal 1..15: DMA wait cycles before a cycle is stolen from the CPU.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 cpu_ma  in  32  CPU byte address, driven every cycle.
REQ-006 cpu_mdout  in  32  CPU write data.
REQ-007 cpu_mwe  in  1  CPU write enable.
REQ-008 cpu_mdin  out  32  CPU read data.
REQ-009 cpu_stall  out  1  CPU clock-enable inverse; CPU holds all state and outputs while high.
REQ-010 dma_req  in  1  DMA (laser point fetch) access request, held until granted.
REQ-011 dma_addr  in  32  DMA byte address.
REQ-012 dma_we  in  1  DMA write enable.
REQ-013 dma_wdata  in  32  DMA write data.
REQ-014 dma_gnt  out  1  DMA access performed this cycle.
REQ-015 dma_rvalid  out  1  DMA read data valid.
REQ-016 dma_rdata  out  32  DMA read data.
REQ-017 mem_addr  out  ADDR_W  RAM word address.
REQ-018 mem_din  out  32  RAM write data.
REQ-019 mem_we  out  1  RAM write enable.
REQ-020 mem_dout  in  32  RAM read data, valid one cycle after address.

Function
REQ-021 Exactly one RAM access per cycle; the owner is the CPU unless the DMA is granted.
REQ-022 wait_cnt (4 bits): +1 each cycle dma_req=1 and dma_gnt=0; cleared on grant or when dma_req=0.
REQ-023 dma_gnt = dma_req AND wait_cnt==MAX_WAIT, combinational; cpu_stall = dma_gnt.
REQ-024 Consequence: grants are separated by at least MAX_WAIT CPU cycles; DMA latency from req = MAX_WAIT cycles.
REQ-025 Address mux: mem_addr = (dma_gnt ? dma_addr : cpu_ma)[ADDR_W+1:2]; bits 31 and above ADDR_W+1 ignored.
REQ-026 mem_din = dma_gnt ? dma_wdata : cpu_mdout; mem_we = dma_gnt ? (dma_we per REQ-036) : cpu_mwe.
REQ-027 owner_q register: 1 if cycle was a DMA access, else 0; next cycle's mem_dout belongs to owner_q.
REQ-028 dma_rvalid registered: 1 in cycle after a DMA read grant (dma_we=0), else 0; dma_rdata = mem_dout.
REQ-029 cpu_hold register: loads mem_dout on every clock where owner_q=0.
REQ-030 cpu_mdin = owner_q ? cpu_hold : mem_dout, so CPU sees its last read result across a stolen cycle.
REQ-031 CPU write during a stolen cycle is suppressed; CPU re-presents it after cpu_stall falls.
REQ-032 dma_req dropped before grant: no access, wait_cnt cleared, no rvalid.

Reset
REQ-033 While reset=1: dma_gnt=0, cpu_stall=0, mem_we=cpu_mwe, owner_q=0, dma_rvalid=0, wait_cnt=0, cpu_hold=0.
REQ-034 Reset asserted in the cycle after a DMA read grant: dma_rvalid forced 0; read data discarded.
REQ-035 First cycle after reset: CPU owns RAM regardless of dma_req.

Configuration
REQ-036 Macro MEM_ARB_DMA_WRITE_EN: defined -> dma_we honoured; undefined -> dma_we ignored, DMA accesses are reads only, mem_we never from DMA, dma_rvalid follows every grant.

Verification
REQ-037 CPU-only: dma_req=0, cpu_ma=0x80000010 read, mem word4=0xDEADBEEF -> mem_addr=4, cpu_mdin=0xDEADBEEF next cycle, cpu_stall never 1.
REQ-038 DMA read, MAX_WAIT=4: dma_req at cycle 10, dma_addr=0x20 -> dma_gnt and cpu_stall at cycle 14 only, mem_addr=8, dma_rvalid at 15 with word8.
REQ-039 Stall transparency: CPU read word2=0x11111111 at cycle 13, DMA stolen at 14 reading 0x22222222 -> cpu_mdin=0x11111111 in cycles 14 and 15.
REQ-040 Continuous dma_req for 20 cycles, MAX_WAIT=4 -> grants at cycles 4,9,14,19; CPU owns all others.
REQ-041 DMA write 0xCAFEF00D to 0x40 with CPU write pending -> mem_we=1 with DMA data at grant; CPU write to RAM next cycle; without MEM_ARB_DMA_WRITE_EN word16 unchanged and dma_rvalid=1.
REQ-042 Reset in cycle after DMA read grant -> dma_rvalid=0, owner_q=0, wait_cnt=0 next cycle.

Source files
------------

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - CPU/DMA single-port RAM arbiter that steals one CPU cycle per DMA access
// Optional: define MEM_ARB_DMA_WRITE_EN to let DMA grants write the RAM (otherwise DMA is read-only).
module mem_arb #(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cpu_ma,
    input  logic [31:0]       cpu_mdout,
    input  logic              cpu_mwe,
    output logic [31:0]       cpu_mdin,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic [31:0]       dma_addr,
    input  logic              dma_we,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_we,
    input  logic [31:0]       mem_dout
);

    logic [3:0]  wait_cnt;
    logic        owner_q;
    logic        rvalid_q;
    logic [31:0] cpu_hold;
    logic        dma_wr;

`ifdef MEM_ARB_DMA_WRITE_EN
    assign dma_wr = dma_we;
`else
    logic unused_dma_we;
    assign unused_dma_we = dma_we;
    assign dma_wr        = 1'b0;
`endif

    // Byte-offset and high address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_ma[31:ADDR_W+2], cpu_ma[1:0],
                                dma_addr[31:ADDR_W+2], dma_addr[1:0]};

    assign dma_gnt   = !reset && dma_req && (wait_cnt == 4'(MAX_WAIT));
    assign cpu_stall = dma_gnt;

    assign mem_addr = dma_gnt ? dma_addr[ADDR_W+1:2] : cpu_ma[ADDR_W+1:2];
    assign mem_din  = dma_gnt ? dma_wdata : cpu_mdout;
    assign mem_we   = dma_gnt ? dma_wr : cpu_mwe;

    // Read data of a DMA grant lands one cycle later; reset in that cycle discards it.
    assign dma_rvalid = rvalid_q && !reset;
    assign dma_rdata  = mem_dout;

    // After a stolen cycle the RAM output belongs to the DMA, so the CPU sees its held word.
    assign cpu_mdin = owner_q ? cpu_hold : mem_dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 4'd0;
            owner_q  <= 1'b0;
            rvalid_q <= 1'b0;
            cpu_hold <= 32'd0;
        end else begin
            wait_cnt <= (dma_req && !dma_gnt) ? wait_cnt + 4'd1 : 4'd0;
            owner_q  <= dma_gnt;
            rvalid_q <= dma_gnt && !dma_wr;
            if (!owner_q)
                cpu_hold <= mem_dout;
        end
    end

endmodule
